// File: rtl/bcd_to_excess3_serial.sv
// Serial BCD-to-Excess-3 encoder: LSB-first digit in on X, offset-added code out on Z
// in the same cycle, completed digit presented in parallel with Done and Err.
module bcd_to_excess3_serial #(
    parameter logic [3:0] OFFSET = 4'd3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       X,
    input  logic       Start,
    output logic       Z,
    output logic       Zv,
    output logic       Done,
    output logic [3:0] Digit_out,
    output logic       Err
);

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [IDX_W-1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 carry_q, carry_d;
    logic [2:0]           enc_q,   enc_d;
    logic [1:0]           in_q,    in_d;
    logic                 done_q,  done_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic                 err_q,   err_d;

    logic [IDX_W-1:0]     bit_idx_c;
    logic [IDX_W-1:0]     idx_next_c;
    logic                 cin_c;
    logic                 off_c;
    logic                 zv_c;
    logic                 z_raw_c;
    logic                 cout_c;

    // Start always restarts at bit 0 with a clean carry, whatever the state.
    always_comb begin
        bit_idx_c  = Start ? IDX_W'(0) : IDX_W'(state_q);
        idx_next_c = bit_idx_c + IDX_W'(1);
        cin_c      = Start ? 1'b0 : carry_q;
        off_c      = OFFSET[bit_idx_c];
        zv_c       = Start | (state_q != IDLE);
        z_raw_c    = X ^ off_c ^ cin_c;
        cout_c     = (X & off_c) | (X & cin_c) | (off_c & cin_c);
    end

    assign Z  = zv_c & z_raw_c;
    assign Zv = zv_c;

    // Next-state: shift encoded/input bits in, complete the digit on bit 3.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        enc_d   = enc_q;
        in_d    = in_q;
        done_d  = 1'b0;
        digit_d = digit_q;
        err_d   = err_q;
        if (zv_c) begin
            if (bit_idx_c == IDX_W'(3)) begin
                state_d = IDLE;
                carry_d = 1'b0;
                digit_d = {z_raw_c, enc_q};
                err_d   = (X & (in_q[1] | in_q[0])) | cout_c;
                done_d  = 1'b1;
            end else begin
                state_d = state_e'(idx_next_c);
                carry_d = cout_c;
                enc_d   = {z_raw_c, enc_q[2:1]};
                in_d    = {X, in_q[1]};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            enc_q   <= 3'b000;
            in_q    <= 2'b00;
            done_q  <= 1'b0;
            digit_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            enc_q   <= enc_d;
            in_q    <= in_d;
            done_q  <= done_d;
            digit_q <= digit_d;
            err_q   <= err_d;
        end
    end

    assign Done      = done_q;
    assign Digit_out = digit_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Directed self-checking bench for the serial BCD-to-Excess-3 encoder.
module tb_bcd_to_excess3_serial;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       X;
    logic       Start;
    logic       Z;
    logic       Zv;
    logic       Done;
    logic [3:0] Digit_out;
    logic       Err;

    int checks   = 0;
    int failures = 0;

    bcd_to_excess3_serial #(.OFFSET(4'd3)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .X         (X),
        .Start     (Start),
        .Z         (Z),
        .Zv        (Zv),
        .Done      (Done),
        .Digit_out (Digit_out),
        .Err       (Err)
    );

    always #5 Clk = ~Clk;

    // One clock: drive inputs, sample Mealy outputs mid-cycle, return 1 time unit after the edge.
    task automatic step(input logic x, input logic s, output logic z, output logic zv);
        X     = x;
        Start = s;
        #1;
        z  = Z;
        zv = Zv;
        @(posedge Clk);
        #1;
    endtask

    // Send one 4-bit frame LSB first with Start on bit 0; returns Z bits and AND of Zv.
    task automatic send_digit(input logic [3:0] d, output logic [3:0] zb, output logic zv_all);
        logic z, zv;
        zv_all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(d[i], (i == 0), z, zv);
            zb[i]  = z;
            zv_all = zv_all & zv;
        end
    endtask

    task automatic test_reset();
        logic z, zv;
        Rst = 1'b1;
        step(1'b1, 1'b0, z, zv);
        step(1'b1, 1'b0, z, zv);
        Rst = 1'b0;
        checks++;
        if (Done !== 1'b0 || Digit_out !== 4'b0000 || Err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got done=%b digit=%b err=%b want 0 0000 0", Done, Digit_out, Err);
        end
        step(1'b1, 1'b0, z, zv);
        checks++;
        if (zv !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_z: got zv=%b z=%b want 0 0", zv, z);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] zb, want;
        logic       zv_all, z, zv;
        for (int d = 0; d < 10; d++) begin
            want = 4'(d + 3);
            send_digit(4'(d), zb, zv_all);
            checks++;
            if (zb !== want || zv_all !== 1'b1) begin
                failures++;
                $display("FAIL sweep_z d=%0d: got z=%b zv_all=%b want %b 1", d, zb, zv_all, want);
            end
            checks++;
            if (Done !== 1'b1 || Digit_out !== want || Err !== 1'b0) begin
                failures++;
                $display("FAIL sweep_done d=%0d: got done=%b digit=%b err=%b want 1 %b 0",
                         d, Done, Digit_out, Err, want);
            end
            step(1'b0, 1'b0, z, zv);
            checks++;
            if (Done !== 1'b0 || Digit_out !== want) begin
                failures++;
                $display("FAIL sweep_pulse d=%0d: got done=%b digit=%b want 0 %b", d, Done, Digit_out, want);
            end
        end
        send_digit(4'b0101, zb, zv_all);
        checks++;
        if (zb !== 4'b1000 || Digit_out !== 4'b1000 || Err !== 1'b0) begin
            failures++;
            $display("FAIL sweep_0101: got z=%b digit=%b err=%b want 1000 1000 0", zb, Digit_out, Err);
        end
        step(1'b0, 1'b0, z, zv);
    endtask

    task automatic test_invalid();
        logic [3:0] zb;
        logic       zv_all, z, zv;
        send_digit(4'b1010, zb, zv_all);
        checks++;
        if (Done !== 1'b1 || Digit_out !== 4'b1101 || Err !== 1'b1 || zb !== 4'b1101) begin
            failures++;
            $display("FAIL invalid_1010: got done=%b digit=%b err=%b z=%b want 1 1101 1 1101",
                     Done, Digit_out, Err, zb);
        end
        send_digit(4'b1111, zb, zv_all);
        checks++;
        if (Done !== 1'b1 || Digit_out !== 4'b0010 || Err !== 1'b1) begin
            failures++;
            $display("FAIL invalid_1111: got done=%b digit=%b err=%b want 1 0010 1", Done, Digit_out, Err);
        end
        send_digit(4'b0000, zb, zv_all);
        checks++;
        if (Done !== 1'b1 || Digit_out !== 4'b0011 || Err !== 1'b0) begin
            failures++;
            $display("FAIL invalid_recover: got done=%b digit=%b err=%b want 1 0011 0", Done, Digit_out, Err);
        end
        step(1'b0, 1'b0, z, zv);
    endtask

    task automatic test_back_to_back();
        logic [3:0] d, want;
        logic       z, zv;
        int         bad_done = 0;
        int         bad_digit = 0;
        int         bad_zv = 0;
        for (int n = 0; n < 10; n++) begin
            d    = 4'(9 - n);
            want = 4'(12 - n);
            for (int i = 0; i < 4; i++) begin
                step(d[i], (i == 0), z, zv);
                if (zv !== 1'b1) bad_zv++;
                if (Done !== (i == 3)) bad_done++;
                if (i == 3 && Digit_out !== want) bad_digit++;
            end
        end
        checks++;
        if (bad_done != 0) begin
            failures++;
            $display("FAIL b2b_done_spacing: got %0d misplaced cycles want 0", bad_done);
        end
        checks++;
        if (bad_digit != 0 || bad_zv != 0) begin
            failures++;
            $display("FAIL b2b_digits: got %0d wrong digits %0d zv drops want 0 0", bad_digit, bad_zv);
        end
        step(1'b0, 1'b0, z, zv);
        checks++;
        if (Done !== 1'b0 || Digit_out !== 4'b0011) begin
            failures++;
            $display("FAIL b2b_tail: got done=%b digit=%b want 0 0011", Done, Digit_out);
        end
    endtask

    task automatic test_resync();
        logic z, zv;
        int   early_done = 0;
        step(1'b1, 1'b1, z, zv);
        if (Done !== 1'b0) early_done++;
        step(1'b1, 1'b0, z, zv);
        if (Done !== 1'b0) early_done++;
        // digit 2 restarts at what would have been bit 2 of the 7
        step(1'b0, 1'b1, z, zv);
        if (Done !== 1'b0) early_done++;
        step(1'b1, 1'b0, z, zv);
        if (Done !== 1'b0) early_done++;
        step(1'b0, 1'b0, z, zv);
        if (Done !== 1'b0) early_done++;
        checks++;
        if (early_done != 0 || Digit_out !== 4'b0011) begin
            failures++;
            $display("FAIL resync_no_done: got %0d early dones digit=%b want 0 0011", early_done, Digit_out);
        end
        step(1'b0, 1'b0, z, zv);
        checks++;
        if (Done !== 1'b1 || Digit_out !== 4'b0101 || Err !== 1'b0) begin
            failures++;
            $display("FAIL resync_done: got done=%b digit=%b err=%b want 1 0101 0", Done, Digit_out, Err);
        end
        step(1'b0, 1'b0, z, zv);
    endtask

    task automatic test_reset_midframe();
        logic [3:0] zb;
        logic       zv_all, z, zv;
        step(1'b1, 1'b1, z, zv);
        step(1'b0, 1'b0, z, zv);
        Rst = 1'b1;
        step(1'b1, 1'b0, z, zv);
        Rst = 1'b0;
        checks++;
        if (Done !== 1'b0 || Digit_out !== 4'b0000 || Err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got done=%b digit=%b err=%b want 0 0000 0", Done, Digit_out, Err);
        end
        step(1'b1, 1'b0, z, zv);
        checks++;
        if (zv !== 1'b0 || z !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle: got zv=%b z=%b done=%b want 0 0 0", zv, z, Done);
        end
        send_digit(4'b1001, zb, zv_all);
        checks++;
        if (Done !== 1'b1 || Digit_out !== 4'b1100 || Err !== 1'b0 || zb !== 4'b1100) begin
            failures++;
            $display("FAIL midreset_next: got done=%b digit=%b err=%b z=%b want 1 1100 0 1100",
                     Done, Digit_out, Err, zb);
        end
        step(1'b0, 1'b0, z, zv);
    endtask

    task automatic test_idle();
        logic z, zv;
        int   bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, z, zv);
            if (zv !== 1'b0 || z !== 1'b0 || Done !== 1'b0 || Digit_out !== 4'b1100) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        Rst   = 1'b1;
        X     = 1'b0;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_sweep();
        test_invalid();
        test_back_to_back();
        test_resync();
        test_reset_midframe();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
